// File: rtl/hall_conditioner_pkg.sv
// Hall sensor code definitions shared by the conditioner and the motor driver.
// Holds the forward code sequence, the invalid codes and code-to-index helpers.
package hall_conditioner_pkg;

  localparam int unsigned HALL_WIDTH = 3;

  // Forward rotation order, index 0..5, wrapping from index 5 back to 0
  localparam logic [HALL_WIDTH-1:0] HALL_S0 = 3'b101;
  localparam logic [HALL_WIDTH-1:0] HALL_S1 = 3'b100;
  localparam logic [HALL_WIDTH-1:0] HALL_S2 = 3'b110;
  localparam logic [HALL_WIDTH-1:0] HALL_S3 = 3'b010;
  localparam logic [HALL_WIDTH-1:0] HALL_S4 = 3'b011;
  localparam logic [HALL_WIDTH-1:0] HALL_S5 = 3'b001;
  localparam logic [HALL_WIDTH-1:0] HALL_BAD_LO = 3'b000;
  localparam logic [HALL_WIDTH-1:0] HALL_BAD_HI = 3'b111;

  typedef enum logic [2:0] {
    TR_NONE,
    TR_FWD,
    TR_REV,
    TR_SKIP,
    TR_LOST,
    TR_FOUND
  } trans_t;

  function automatic logic hall_is_valid(input logic [HALL_WIDTH-1:0] code);
    return (code != HALL_BAD_LO) && (code != HALL_BAD_HI);
  endfunction

  function automatic logic [2:0] hall_index(input logic [HALL_WIDTH-1:0] code);
    logic [2:0] idx;
    case (code)
      HALL_S0: idx = 3'd0;
      HALL_S1: idx = 3'd1;
      HALL_S2: idx = 3'd2;
      HALL_S3: idx = 3'd3;
      HALL_S4: idx = 3'd4;
      HALL_S5: idx = 3'd5;
      default: idx = 3'd7;
    endcase
    return idx;
  endfunction

  function automatic logic [2:0] index_next(input logic [2:0] idx);
    return (idx == 3'd5) ? 3'd0 : idx + 3'd1;
  endfunction

  function automatic trans_t hall_classify(input logic [HALL_WIDTH-1:0] old_code,
                                           input logic [HALL_WIDTH-1:0] new_code);
    trans_t t;
    if (!hall_is_valid(new_code))
      t = TR_LOST;
    else if (!hall_is_valid(old_code))
      t = TR_FOUND;
    else if (hall_index(new_code) == index_next(hall_index(old_code)))
      t = TR_FWD;
    else if (hall_index(old_code) == index_next(hall_index(new_code)))
      t = TR_REV;
    else
      t = TR_SKIP;
    return t;
  endfunction

endpackage

// File: rtl/hall_conditioner_filter.sv
// Synchroniser plus debounce for the raw hall inputs.
// Presents the filtered code and a combinational accept pulse for the coming edge.
module hall_filter
  import hall_conditioner_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [HALL_WIDTH-1:0] hall_raw,
  output logic [HALL_WIDTH-1:0] hall,
  output logic [HALL_WIDTH-1:0] next_code,
  output logic                  accept
);

  localparam int unsigned CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES - 1);

  logic [HALL_WIDTH-1:0] sync [SYNC_STAGES];
  logic [HALL_WIDTH-1:0] synced;
  logic [HALL_WIDTH-1:0] cand;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         next_cnt;

  // The accept test uses the updated count, so the cycle that reloads cand
  // counts as the first stable cycle and the latency is SYNC_STAGES+FILTER_CYCLES.
  always_comb begin
    synced    = sync[SYNC_STAGES-1];
    next_code = synced;
    if (synced != cand)
      next_cnt = '0;
    else if (cnt == CNT_MAX)
      next_cnt = cnt;
    else
      next_cnt = cnt + 1'b1;
    accept = (next_cnt == CNT_MAX) && (synced != hall);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++)
        sync[i] <= '0;
      cand <= '0;
      cnt  <= '0;
      hall <= '0;
    end else begin
      sync[0] <= hall_raw;
      for (int unsigned i = 1; i < SYNC_STAGES; i++)
        sync[i] <= sync[i-1];
      cand <= synced;
      cnt  <= next_cnt;
      if (accept)
        hall <= synced;
    end
  end

endmodule

// File: rtl/hall_conditioner.sv
// Hall sensor conditioner: filtered code, step/direction classification,
// commutation period measurement, stall detection and sticky sequence error.
module hall_conditioner
  import hall_conditioner_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 16,
  parameter int unsigned PERIOD_WIDTH  = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [HALL_WIDTH-1:0]   hall_raw,
  input  logic                    clear_error,
  output logic [HALL_WIDTH-1:0]   hall,
  output logic                    hall_valid,
  output logic                    step_strobe,
  output logic                    direction,
  output logic [PERIOD_WIDTH-1:0] period,
  output logic                    period_valid,
  output logic                    stall,
  output logic                    seq_error
);

  localparam logic [PERIOD_WIDTH-1:0] CNT_SAT = '1;

  logic [HALL_WIDTH-1:0]   next_code;
  logic                    accept;
  logic [PERIOD_WIDTH-1:0] count;
  logic                    ref_ok;
  trans_t                  trans;

  hall_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_filter (
    .clock    (clock),
    .reset    (reset),
    .hall_raw (hall_raw),
    .hall     (hall),
    .next_code(next_code),
    .accept   (accept)
  );

  always_comb begin
    trans = TR_NONE;
    if (accept)
      trans = hall_classify(hall, next_code);
  end

  // ref_ok: a strobe has occurred with no error, stall or invalid code since.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hall_valid   <= 1'b0;
      step_strobe  <= 1'b0;
      direction    <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      stall        <= 1'b0;
      seq_error    <= 1'b0;
      count        <= '0;
      ref_ok       <= 1'b0;
    end else begin
      step_strobe <= 1'b0;
      if (clear_error)
        seq_error <= 1'b0;
      case (trans)
        TR_FWD, TR_REV: begin
          step_strobe  <= 1'b1;
          direction    <= (trans == TR_FWD);
          period       <= count;
          period_valid <= ref_ok;
          ref_ok       <= 1'b1;
          stall        <= 1'b0;
          count        <= PERIOD_WIDTH'(1);
        end
        TR_SKIP: begin
          seq_error    <= 1'b1;
          period_valid <= 1'b0;
          ref_ok       <= 1'b0;
          count        <= PERIOD_WIDTH'(1);
        end
        TR_FOUND: begin
          hall_valid   <= 1'b1;
          period_valid <= 1'b0;
          ref_ok       <= 1'b0;
          count        <= PERIOD_WIDTH'(1);
        end
        TR_LOST: begin
          hall_valid   <= 1'b0;
          period_valid <= 1'b0;
          ref_ok       <= 1'b0;
          count        <= '0;
        end
        default: begin
          if (hall_valid && (count != CNT_SAT)) begin
            count <= count + 1'b1;
            if (count == CNT_SAT - 1'b1) begin
              stall        <= 1'b1;
              period_valid <= 1'b0;
              ref_ok       <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hall_conditioner.sv
// Directed bench for hall_conditioner: a 16-bit period instance and an
// 8-bit period instance for stall, with a strobe scoreboard per instance.
module tb_hall_conditioner;

  typedef struct {
    logic        dir;
    logic [15:0] per;
    logic        pv;
    logic        chk_per;
  } step_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  raw_a = 3'b000;
  logic [2:0]  raw_b = 3'b000;
  logic        clr_a = 1'b0;
  logic        clr_b = 1'b0;

  logic [2:0]  hall_a, hall_b;
  logic        hv_a, hv_b, stb_a, stb_b, dir_a, dir_b;
  logic [15:0] per_a;
  logic [7:0]  per_b;
  logic        pv_a, pv_b, stall_a, stall_b, err_a, err_b;

  int tests    = 0;
  int failures = 0;
  step_t q_a[$];
  step_t q_b[$];

  always #5 clock = ~clock;

  hall_conditioner #(.SYNC_STAGES(2), .FILTER_CYCLES(4), .PERIOD_WIDTH(16)) dut_a (
    .clock(clock), .reset(reset), .hall_raw(raw_a), .clear_error(clr_a),
    .hall(hall_a), .hall_valid(hv_a), .step_strobe(stb_a), .direction(dir_a),
    .period(per_a), .period_valid(pv_a), .stall(stall_a), .seq_error(err_a)
  );

  hall_conditioner #(.SYNC_STAGES(2), .FILTER_CYCLES(4), .PERIOD_WIDTH(8)) dut_b (
    .clock(clock), .reset(reset), .hall_raw(raw_b), .clear_error(clr_b),
    .hall(hall_b), .hall_valid(hv_b), .step_strobe(stb_b), .direction(dir_b),
    .period(per_b), .period_valid(pv_b), .stall(stall_b), .seq_error(err_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push_a(input logic dir, input logic [15:0] per, input logic pv, input logic cp);
    step_t s;
    s.dir = dir; s.per = per; s.pv = pv; s.chk_per = cp;
    q_a.push_back(s);
  endtask

  task automatic push_b(input logic dir, input logic [15:0] per, input logic pv, input logic cp);
    step_t s;
    s.dir = dir; s.per = per; s.pv = pv; s.chk_per = cp;
    q_b.push_back(s);
  endtask

  always @(negedge clock) begin
    if (stb_a) begin
      chk("a_strobe_expected", 32'(q_a.size() != 0), 32'd1);
      if (q_a.size() != 0) begin
        step_t s;
        s = q_a.pop_front();
        chk("a_direction", 32'(dir_a), 32'(s.dir));
        chk("a_period_valid", 32'(pv_a), 32'(s.pv));
        if (s.chk_per) chk("a_period", 32'(per_a), 32'(s.per));
      end
    end
    if (stb_b) begin
      chk("b_strobe_expected", 32'(q_b.size() != 0), 32'd1);
      if (q_b.size() != 0) begin
        step_t s;
        s = q_b.pop_front();
        chk("b_direction", 32'(dir_b), 32'(s.dir));
        chk("b_period_valid", 32'(pv_b), 32'(s.pv));
        if (s.chk_per) chk("b_period", 32'(per_b), 32'(s.per));
      end
    end
  end

  initial begin
    logic [2:0] fwd [6];
    fwd[0] = 3'b101; fwd[1] = 3'b100; fwd[2] = 3'b110;
    fwd[3] = 3'b010; fwd[4] = 3'b011; fwd[5] = 3'b001;

    // Reset state
    #1 reset = 1'b1;
    #1;
    chk("rst_hall", 32'(hall_a), 32'd0);
    chk("rst_hall_valid", 32'(hv_a), 32'd0);
    chk("rst_strobe", 32'(stb_a), 32'd0);
    chk("rst_direction", 32'(dir_a), 32'd0);
    chk("rst_period", 32'(per_a), 32'd0);
    chk("rst_period_valid", 32'(pv_a), 32'd0);
    chk("rst_stall", 32'(stall_a), 32'd0);
    chk("rst_seq_error", 32'(err_a), 32'd0);
    tick(2);
    reset = 1'b0;

    // 1: first code accepted exactly SYNC_STAGES+FILTER_CYCLES cycles later
    raw_a = 3'b101;
    tick(5);
    chk("t1_hall_not_early", 32'(hall_a), 32'd0);
    tick(1);
    chk("t1_hall", 32'(hall_a), 32'b101);
    chk("t1_hall_valid", 32'(hv_a), 32'd1);
    chk("t1_seq_error", 32'(err_a), 32'd0);
    tick(10);

    // 2: a 3-cycle glitch is rejected
    raw_a = 3'b100;
    tick(3);
    raw_a = 3'b101;
    tick(20);
    chk("t2_hall", 32'(hall_a), 32'b101);

    // 3: full forward revolution, 1000 cycles per code
    for (int i = 1; i <= 6; i++) begin
      raw_a = fwd[i % 6];
      push_a(1'b1, 16'd1000, (i != 1), (i != 1));
      tick(1000);
    end
    chk("t3_hall", 32'(hall_a), 32'b101);
    chk("t3_direction", 32'(dir_a), 32'd1);

    // 4: forward to 110, then reverse 100, 101
    raw_a = 3'b100; push_a(1'b1, 16'd1000, 1'b1, 1'b1); tick(1000);
    raw_a = 3'b110; push_a(1'b1, 16'd1000, 1'b1, 1'b1); tick(1000);
    raw_a = 3'b100; push_a(1'b0, 16'd1000, 1'b1, 1'b1); tick(1000);
    raw_a = 3'b101; push_a(1'b0, 16'd1000, 1'b1, 1'b1); tick(1000);
    chk("t4_direction", 32'(dir_a), 32'd0);
    chk("t4_period_valid", 32'(pv_a), 32'd1);

    // 5: non-adjacent jump, clear, then error coincident with clear
    raw_a = 3'b010;
    tick(20);
    chk("t5_hall", 32'(hall_a), 32'b010);
    chk("t5_seq_error", 32'(err_a), 32'd1);
    chk("t5_period_valid", 32'(pv_a), 32'd0);
    chk("t5_direction_kept", 32'(dir_a), 32'd0);
    clr_a = 1'b1; tick(1); clr_a = 1'b0;
    chk("t5_cleared", 32'(err_a), 32'd0);
    tick(10);
    raw_a = 3'b101;
    tick(5);
    chk("t5_no_early_error", 32'(err_a), 32'd0);
    clr_a = 1'b1; tick(1); clr_a = 1'b0;
    chk("t5_error_wins", 32'(err_a), 32'd1);
    chk("t5_hall2", 32'(hall_a), 32'b101);
    tick(1);
    chk("t5_error_sticky", 32'(err_a), 32'd1);

    // 6: stall on the 8-bit instance, recovery strobe, then invalid code
    raw_b = 3'b101;
    tick(20);
    chk("t6_hall_valid", 32'(hv_b), 32'd1);
    raw_b = 3'b100;
    push_b(1'b1, 16'd0, 1'b0, 1'b0);
    tick(200);
    chk("t6_no_stall_yet", 32'(stall_b), 32'd0);
    tick(100);
    chk("t6_stall", 32'(stall_b), 32'd1);
    chk("t6_stall_pv", 32'(pv_b), 32'd0);
    raw_b = 3'b110;
    push_b(1'b1, 16'd255, 1'b0, 1'b1);
    tick(20);
    chk("t6_stall_cleared", 32'(stall_b), 32'd0);
    chk("t6_pv_after_stall", 32'(pv_b), 32'd0);
    raw_b = 3'b111;
    tick(20);
    chk("t6_hall_111", 32'(hall_b), 32'b111);
    chk("t6_invalid", 32'(hv_b), 32'd0);

    // Reset mid-operation
    reset = 1'b1;
    #1;
    chk("mid_rst_hall", 32'(hall_a), 32'd0);
    chk("mid_rst_seq_error", 32'(err_a), 32'd0);
    chk("mid_rst_hall_valid", 32'(hv_a), 32'd0);
    chk("mid_rst_period", 32'(per_a), 32'd0);
    tick(2);
    reset = 1'b0;
    tick(20);
    chk("mid_rst_reaccept", 32'(hall_a), 32'b101);

    chk("queue_a_drained", 32'(q_a.size()), 32'd0);
    chk("queue_b_drained", 32'(q_b.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
